// File: rtl/pingpong_buf_ctrl.sv
// pingpong_buf_ctrl
// Double-buffer write sequencer between the median filter and the PicoBlaze.
// Samples fill one half of a 2*DEPTH-entry RAM while the CPU reads the other
// half. A completed half raises an interrupt and is held until software
// releases it with done_i.
//
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   sample_i, sample_valid_i      median result and its one-cycle strobe
//   ram_we_o/ram_waddr_o/ram_wdata_o  RAM port-A write, address = {bank, ptr}
//   irq_o, irq_ack_i              PicoBlaze interrupt request / acknowledge
//   rd_bank_o                     bank software must read (read-address MSB)
//   done_i                        software release of the bank being read
//   clr_i                         clear overrun flag and drop count
//   overrun_o, drop_cnt_o         sticky drop flag, saturating drop count
//
// Write FSM
//   state   | meaning
//   WR_FILL | writing samples into wr_bank
//   WR_WAIT | both banks full, incoming samples are dropped
// Read FSM
//   state   | meaning
//   RD_IDLE | waiting for bank rd_next to become full
//   RD_IRQ  | irq_o raised for rd_bank_o, waiting for ack
//   RD_BUSY | CPU reading rd_bank_o, waiting for done_i
module pingpong_buf_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              irq_o,
  input  logic              irq_ack_i,
  output logic              rd_bank_o,
  input  logic              done_i,
  input  logic              clr_i,
  output logic              overrun_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int PTR_W = ADDR_W - 1;

  typedef enum logic {WR_FILL, WR_WAIT} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_IRQ, RD_BUSY} rd_state_t;

  wr_state_t         wr_state, wr_state_nxt;
  rd_state_t         rd_state, rd_state_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [1:0]        full, full_nxt;
  logic              rd_next, rd_next_nxt;
  logic              rd_bank_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              irq_nxt;
  logic              done_fire;
  logic              other_free;
  logic              drop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_state    <= WR_FILL;
      rd_state    <= RD_IDLE;
      wr_bank     <= 1'b0;
      wr_ptr      <= '0;
      full        <= 2'b00;
      rd_next     <= 1'b0;
      rd_bank_o   <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_waddr_o <= '0;
      ram_wdata_o <= '0;
      irq_o       <= 1'b0;
    end else begin
      wr_state    <= wr_state_nxt;
      rd_state    <= rd_state_nxt;
      wr_bank     <= wr_bank_nxt;
      wr_ptr      <= wr_ptr_nxt;
      full        <= full_nxt;
      rd_next     <= rd_next_nxt;
      rd_bank_o   <= rd_bank_nxt;
      ram_we_o    <= we_nxt;
      ram_waddr_o <= waddr_nxt;
      ram_wdata_o <= wdata_nxt;
      irq_o       <= irq_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    rd_state_nxt = rd_state;
    wr_bank_nxt  = wr_bank;
    wr_ptr_nxt   = wr_ptr;
    full_nxt     = full;
    rd_next_nxt  = rd_next;
    rd_bank_nxt  = rd_bank_o;
    we_nxt       = 1'b0;
    waddr_nxt    = ram_waddr_o;
    wdata_nxt    = ram_wdata_o;
    drop         = 1'b0;

    done_fire = (rd_state == RD_BUSY) && done_i;
    // A release landing this cycle counts as free so the writer never stalls
    // a cycle longer than needed.
    other_free = !full[~wr_bank] || (done_fire && (rd_bank_o != wr_bank));

    if (done_fire) begin
      full_nxt[rd_bank_o] = 1'b0;
    end

    case (wr_state)
      WR_FILL: begin
        if (sample_valid_i) begin
          we_nxt    = 1'b1;
          waddr_nxt = {wr_bank, wr_ptr};
          wdata_nxt = sample_i;
          if (wr_ptr == PTR_W'(DEPTH - 1)) begin
            full_nxt[wr_bank] = 1'b1;
            wr_ptr_nxt        = '0;
            if (other_free) begin
              wr_bank_nxt = ~wr_bank;
            end else begin
              wr_state_nxt = WR_WAIT;
            end
          end else begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
          end
        end
      end
      WR_WAIT: begin
        if (other_free) begin
          wr_bank_nxt  = ~wr_bank;
          wr_state_nxt = WR_FILL;
          if (sample_valid_i) begin
            we_nxt     = 1'b1;
            waddr_nxt  = {~wr_bank, {PTR_W{1'b0}}};
            wdata_nxt  = sample_i;
            wr_ptr_nxt = PTR_W'(1);
          end
        end else if (sample_valid_i) begin
          drop = 1'b1;
        end
      end
      default: wr_state_nxt = WR_FILL;
    endcase

    case (rd_state)
      RD_IDLE: begin
        if (full[rd_next]) begin
          rd_bank_nxt  = rd_next;
          rd_state_nxt = RD_IRQ;
        end
      end
      RD_IRQ: begin
        if (irq_ack_i) begin
          rd_state_nxt = RD_BUSY;
        end
      end
      RD_BUSY: begin
        if (done_i) begin
          rd_next_nxt  = ~rd_next;
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase

    irq_nxt = (rd_state_nxt == RD_IRQ);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overrun_o  <= 1'b0;
      drop_cnt_o <= 8'd0;
    end else if (clr_i) begin
      overrun_o  <= 1'b0;
      drop_cnt_o <= 8'd0;
    end else if (drop) begin
      overrun_o <= 1'b1;
      if (drop_cnt_o != 8'hFF) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Testbench for pingpong_buf_ctrl (DATA_W=16, DEPTH=8).
// Expected RAM writes are queued as samples are driven and popped by a
// monitor whenever the DUT asserts ram_we_o.
module tb_pingpong_buf_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [15:0] sample_i;
  logic        sample_valid_i;
  logic        ram_we_o;
  logic [3:0]  ram_waddr_o;
  logic [15:0] ram_wdata_o;
  logic        irq_o;
  logic        irq_ack_i;
  logic        rd_bank_o;
  logic        done_i;
  logic        clr_i;
  logic        overrun_o;
  logic [7:0]  drop_cnt_o;

  int n_chk = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];

  pingpong_buf_ctrl #(.DATA_W(16), .DEPTH(8), .ADDR_W(4)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .ram_we_o       (ram_we_o),
    .ram_waddr_o    (ram_waddr_o),
    .ram_wdata_o    (ram_wdata_o),
    .irq_o          (irq_o),
    .irq_ack_i      (irq_ack_i),
    .rd_bank_o      (rd_bank_o),
    .done_i         (done_i),
    .clr_i          (clr_i),
    .overrun_o      (overrun_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rstn_i === 1'b1 && ram_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexp_we", ram_we_o, 0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("waddr", ram_waddr_o, e[19:16]);
        chk("wdata", ram_wdata_o, e[15:0]);
      end
    end
  end

  // Drive one sample; if it should be written, queue its address and data.
  task automatic send(input logic [15:0] d, input bit w, input logic [3:0] a);
    sample_i       = d;
    sample_valid_i = 1'b1;
    if (w) exp_q.push_back({a, d});
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    irq_ack_i = 1'b0;
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    @(posedge clk_i);
    #1;
    done_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},      ram_we_o, 0);
    chk({tag, "_waddr"},   ram_waddr_o, 0);
    chk({tag, "_wdata"},   ram_wdata_o, 0);
    chk({tag, "_irq"},     irq_o, 0);
    chk({tag, "_rd_bank"}, rd_bank_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
    chk({tag, "_drop"},    drop_cnt_o, 0);
  endtask

  // irq rises two cycles after the completing strobe: still low at the first
  // negedge, high with the expected bank at the second.
  task automatic chk_irq_rise(input string tag, input logic bank);
    @(negedge clk_i);
    chk({tag, "_irq_early"}, irq_o, 0);
    @(negedge clk_i);
    chk({tag, "_irq"}, irq_o, 1);
    chk({tag, "_rd_bank"}, rd_bank_o, bank);
  endtask

  initial begin
    rstn_i         = 1'b0;
    sample_i       = '0;
    sample_valid_i = 1'b0;
    irq_ack_i      = 1'b0;
    done_i         = 1'b0;
    clr_i          = 1'b0;
    #12;
    chk_reset_outputs("rst");
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // single fill of bank 0
    for (int i = 0; i < 8; i++) send(16'(16'h0010 + i), 1'b1, 4'(i));
    chk_irq_rise("fill0", 1'b0);
    chk("fill0_pending", exp_q.size(), 0);

    // handshake; stray ack in RD_BUSY is ignored
    pulse_ack();
    @(negedge clk_i);
    chk("ack_irq_low", irq_o, 0);
    pulse_ack();
    @(negedge clk_i);
    chk("stray_ack_irq", irq_o, 0);
    for (int i = 0; i < 4; i++) send(16'(16'h0020 + i), 1'b1, 4'(8 + i));
    pulse_done();
    for (int i = 4; i < 8; i++) send(16'(16'h0020 + i), 1'b1, 4'(8 + i));
    chk_irq_rise("fill1", 1'b1);

    // stray done in RD_IRQ must not free bank 1
    pulse_done();
    @(negedge clk_i);
    chk("stray_done_irq", irq_o, 1);
    chk("stray_done_bank", rd_bank_o, 1);
    pulse_ack();
    pulse_done();
    // stray done in RD_IDLE
    pulse_done();
    @(negedge clk_i);
    chk("idle_irq", irq_o, 0);

    // fill both banks with no release, then overrun
    for (int i = 0; i < 8; i++) send(16'(16'h0030 + i), 1'b1, 4'(i));
    chk_irq_rise("fill2", 1'b0);
    for (int i = 0; i < 8; i++) send(16'(16'h0040 + i), 1'b1, 4'(8 + i));
    for (int i = 0; i < 3; i++) send(16'(16'h0099), 1'b0, 4'd0);
    @(negedge clk_i);
    chk("ovr_flag", overrun_o, 1);
    chk("ovr_cnt", drop_cnt_o, 3);
    chk("ovr_irq_bank", rd_bank_o, 0);
    chk("ovr_pending", exp_q.size(), 0);
    pulse_clr();
    @(negedge clk_i);
    chk("clr_flag", overrun_o, 0);
    chk("clr_cnt", drop_cnt_o, 0);
    // clear beats a simultaneous drop
    clr_i = 1'b1;
    send(16'h0098, 1'b0, 4'd0);
    clr_i = 1'b0;
    @(negedge clk_i);
    chk("clr_win_flag", overrun_o, 0);
    chk("clr_win_cnt", drop_cnt_o, 0);
    for (int i = 0; i < 260; i++) send(16'(i + 1), 1'b0, 4'd0);
    @(negedge clk_i);
    chk("sat_cnt", drop_cnt_o, 255);
    chk("sat_flag", overrun_o, 1);

    // done and sample in the same cycle while waiting
    pulse_ack();
    pulse_clr();
    done_i = 1'b1;
    send(16'h0050, 1'b1, 4'd0);
    done_i = 1'b0;
    chk_irq_rise("simul", 1'b1);
    chk("simul_cnt", drop_cnt_o, 0);
    chk("simul_flag", overrun_o, 0);
    for (int i = 1; i < 5; i++) send(16'(16'h0050 + i), 1'b1, 4'(i));

    // reset mid-fill while irq is high
    @(negedge clk_i);
    chk("pre_rst_irq", irq_o, 1);
    #1;
    rstn_i = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(16'h0060 + i), 1'b1, 4'(i));
    chk_irq_rise("refill", 1'b0);

    repeat (2) @(negedge clk_i);
    chk("final_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
